opponent_attack_ctrl: RTL and testbench

//  Opponent attack sequencer, directly downstream of the LFSR. Drives the LFSR

---
 rtl/opponent_attack_ctrl_if.sv | 25 ++
 rtl/opponent_attack_ctrl.sv | 179 +++++++++++++++++
 tb/tb_opponent_attack_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/opponent_attack_ctrl_if.sv
// Game-side signal bundle for the opponent attack controller.
interface opponent_attack_ctrl_if;
  logic       run;
  logic       tick;
  logic       random_pos;
  logic       dodge_l;
  logic       dodge_r;
  logic       lfsr_enable;
  logic       attack_side;
  logic       windup;
  logic       strike;
  logic       hit_player;
  logic       dodged;
  logic [2:0] state;

  modport master (
    output run, tick, random_pos, dodge_l, dodge_r,
    input  lfsr_enable, attack_side, windup, strike, hit_player, dodged, state
  );

  modport slave (
    input  run, tick, random_pos, dodge_l, dodge_r,
    output lfsr_enable, attack_side, windup, strike, hit_player, dodged, state
  );
endinterface

// File: rtl/opponent_attack_ctrl.sv
// Opponent attack sequencer: gathers LFSR bits, times windup/strike/recover on frame
// ticks and resolves each strike against player dodges. Optional: OPP_SPEEDUP_EN.
module opponent_attack_ctrl #(
  parameter int unsigned BASE_DELAY    = 8,
  parameter int unsigned WINDUP_TICKS  = 12,
  parameter int unsigned STRIKE_TICKS  = 4,
  parameter int unsigned RECOVER_TICKS = 6,
  parameter int unsigned MIN_WINDUP    = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  opponent_attack_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GATHER  = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] WINDUP  = 3'd3;
  localparam logic [2:0] STRIKE  = 3'd4;
  localparam logic [2:0] RECOVER = 3'd5;

  // Reject parameter sets the counters cannot represent.
  if (BASE_DELAY < 1 || WINDUP_TICKS < 1 || STRIKE_TICKS < 1 || RECOVER_TICKS < 1 ||
      MIN_WINDUP < 1 || MIN_WINDUP > WINDUP_TICKS) begin : g_bad_ticks
    $error("opponent_attack_ctrl: tick parameters out of range");
  end
  if ((BASE_DELAY + 3) >= (1 << CNT_W) || (WINDUP_TICKS + 3) >= (1 << CNT_W) ||
      (STRIKE_TICKS + 3) >= (1 << CNT_W) || (RECOVER_TICKS + 3) >= (1 << CNT_W)) begin : g_bad_width
    $error("opponent_attack_ctrl: CNT_W too narrow");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc, wait_len, wlen;
  logic [1:0]       gcnt_q, gcnt_d;
  logic [2:0]       rnd_q, rnd_d;
  logic             side_q, side_d;
  logic             hit_q, hit_d;
  logic             dodged_q, dodged_d;
  logic             correct;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign wait_len = CNT_W'(BASE_DELAY) + CNT_W'(rnd_q[2:1]);
  assign correct  = side_q ? bus.dodge_l : bus.dodge_r;

`ifdef OPP_SPEEDUP_EN
  logic [CNT_W-1:0] wlen_q;

  // Each landed hit shortens the telegraph, floored at MIN_WINDUP.
  always_ff @(posedge clock) begin
    if (reset) begin
      wlen_q <= CNT_W'(WINDUP_TICKS);
    end else if (hit_d && (wlen_q > CNT_W'(MIN_WINDUP))) begin
      wlen_q <= wlen_q - CNT_W'(1);
    end
  end

  assign wlen = wlen_q;
`else
  assign wlen = CNT_W'(WINDUP_TICKS);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      rnd_q    <= '0;
      side_q   <= 1'b0;
      hit_q    <= 1'b0;
      dodged_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      rnd_q    <= rnd_d;
      side_q   <= side_d;
      hit_q    <= hit_d;
      dodged_q <= dodged_d;
    end
  end

  // Next-state and pulse decode; dropping run abandons the attack silently.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    rnd_d    = rnd_q;
    side_d   = side_q;
    hit_d    = 1'b0;
    dodged_d = 1'b0;

    if (!bus.run) begin
      state_d = IDLE;
      cnt_d   = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GATHER;
          cnt_d   = '0;
          gcnt_d  = '0;
        end
        GATHER: begin
          rnd_d  = {rnd_q[1:0], bus.random_pos};
          gcnt_d = gcnt_q + 2'd1;
          if (gcnt_q == 2'd2) begin
            state_d = WAIT;
            side_d  = bus.random_pos;
            gcnt_d  = '0;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          if (bus.tick) begin
            if (cnt_inc == wait_len) begin
              state_d = WINDUP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        WINDUP: begin
          if (bus.tick) begin
            if (cnt_inc == wlen) begin
              state_d = STRIKE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        STRIKE: begin
          // A correct dodge beats a coincident final tick.
          if (correct) begin
            dodged_d = 1'b1;
            state_d  = RECOVER;
            cnt_d    = '0;
          end else if (bus.tick) begin
            if (cnt_inc == CNT_W'(STRIKE_TICKS)) begin
              hit_d   = 1'b1;
              state_d = RECOVER;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        RECOVER: begin
          if (bus.tick) begin
            if (cnt_inc == CNT_W'(RECOVER_TICKS)) begin
              state_d = GATHER;
              cnt_d   = '0;
              gcnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          gcnt_d  = '0;
        end
      endcase
    end
  end

  assign bus.lfsr_enable = (state_q == GATHER);
  assign bus.windup      = (state_q == WINDUP);
  assign bus.strike      = (state_q == STRIKE);
  assign bus.state       = state_q;
  assign bus.attack_side = side_q;
  assign bus.hit_player  = hit_q;
  assign bus.dodged      = dodged_q;

endmodule

// File: tb/tb_opponent_attack_ctrl.sv
// Scoreboard bench for opponent_attack_ctrl; honours OPP_SPEEDUP_EN when defined.
module tb_opponent_attack_ctrl;

  localparam int unsigned BASE_DELAY    = 8;
  localparam int unsigned WINDUP_TICKS  = 12;
  localparam int unsigned STRIKE_TICKS  = 4;
  localparam int unsigned RECOVER_TICKS = 6;
  localparam int unsigned MIN_WINDUP    = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GATHER  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_WINDUP  = 3'd3;
  localparam logic [2:0] S_STRIKE  = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  opponent_attack_ctrl_if bus();

  opponent_attack_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int side;
    int wait_t;
    int windup_t;
    int is_hit;
    int strike_t;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   phase      = 0;
  int   model_wlen = int'(WINDUP_TICKS);

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; a tick strobe is driven every fourth clock.
  task automatic clk1();
    @(posedge clock);
    #1;
    phase    = (phase + 1) % 4;
    bus.tick = (phase == 0);
  endtask

  // Monitor: measures tick counts per phase and scores each outcome pulse.
  initial begin
    logic [2:0] prev_state;
    int wait_t, windup_t, strike_t, recover_t, gather_c, prev_pulse;
    prev_state = S_IDLE;
    wait_t = 0; windup_t = 0; strike_t = 0; recover_t = 0; gather_c = 0; prev_pulse = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_state = bus.state;
        prev_pulse = 0;
      end else begin
        if (prev_pulse != 0)
          chk("pulse_width", int'(bus.hit_player | bus.dodged), 0);
        if (bus.state == S_GATHER && prev_state != S_GATHER) begin
          if (prev_state == S_RECOVER) chk("recover_ticks", recover_t, int'(RECOVER_TICKS));
          gather_c = 0;
        end
        if (bus.state == S_WAIT && prev_state == S_GATHER) begin
          chk("gather_clocks", gather_c, 3);
          if (exp_q.size() > 0) chk("attack_side", int'(bus.attack_side), exp_q[0].side);
          wait_t = 0;
        end
        if (bus.state == S_WINDUP && prev_state == S_WAIT) begin
          chk("windup_rise", int'(bus.windup), 1);
          if (exp_q.size() > 0) chk("wait_ticks", wait_t, exp_q[0].wait_t);
          windup_t = 0;
        end
        if (bus.state == S_STRIKE && prev_state == S_WINDUP) begin
          chk("strike_rise", int'({bus.strike, bus.windup}), 2);
          if (exp_q.size() > 0) chk("windup_ticks", windup_t, exp_q[0].windup_t);
          strike_t = 0;
        end
        if (bus.state == S_RECOVER && prev_state != S_RECOVER) recover_t = 0;
        if (bus.hit_player || bus.dodged) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'({bus.hit_player, bus.dodged}), 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("outcome_hit", int'(bus.hit_player), e.is_hit);
            chk("outcome_dodged", int'(bus.dodged), 1 - e.is_hit);
            chk("strike_ticks", strike_t, e.strike_t);
            chk("pulse_state", int'(bus.state), int'(S_RECOVER));
          end
        end
        prev_pulse = int'(bus.hit_player | bus.dodged);
        if (bus.lfsr_enable) gather_c++;
        if (bus.tick) begin
          case (bus.state)
            S_WAIT:    wait_t++;
            S_WINDUP:  windup_t++;
            S_STRIKE:  strike_t++;
            S_RECOVER: recover_t++;
            default:   ;
          endcase
        end
        prev_state = bus.state;
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input string tag);
    int guard;
    guard = 0;
    while (bus.state != s && guard < 2000) begin
      clk1();
      guard++;
    end
    chk(tag, int'(bus.state), int'(s));
  endtask

  task automatic feed_bits(input logic [2:0] bits);
    wait_state(S_GATHER, "reach_gather");
    bus.random_pos = bits[2];
    clk1();
    bus.random_pos = bits[1];
    clk1();
    bus.random_pos = bits[0];
    clk1();
    bus.random_pos = 1'b0;
  endtask

  // mode 0: no dodge, 1: correct dodge on tick dtick, 2: wrong dodge held, 3: both on tick dtick
  task automatic attack(input logic [2:0] bits, input int mode, input int dtick);
    exp_t e;
    int   n, guard;
    logic fire;
    e.side     = int'(bits[0]);
    e.wait_t   = int'(BASE_DELAY) + int'(bits[2:1]);
    e.windup_t = model_wlen;
    e.is_hit   = (mode == 0 || mode == 2) ? 1 : 0;
    e.strike_t = e.is_hit ? int'(STRIKE_TICKS) : dtick;
`ifdef OPP_SPEEDUP_EN
    if (e.is_hit != 0 && model_wlen > int'(MIN_WINDUP)) model_wlen--;
`endif
    exp_q.push_back(e);
    feed_bits(bits);
    wait_state(S_STRIKE, "reach_strike");
    n = 0;
    guard = 0;
    while (bus.state == S_STRIKE && guard < 200) begin
      if (bus.tick) n++;
      fire = bus.tick && (n == dtick);
      case (mode)
        1:       begin bus.dodge_r = fire & ~bits[0]; bus.dodge_l = fire & bits[0]; end
        2:       begin bus.dodge_r = bits[0];         bus.dodge_l = ~bits[0];       end
        3:       begin bus.dodge_r = fire;            bus.dodge_l = fire;           end
        default: begin bus.dodge_r = 1'b0;            bus.dodge_l = 1'b0;           end
      endcase
      clk1();
      guard++;
    end
    chk("strike_bounded", int'(guard < 200), 1);
    bus.dodge_r = 1'b0;
    bus.dodge_l = 1'b0;
  endtask

  // Abandon an attack mid-STRIKE by dropping run (use_reset=0) or by reset (use_reset=1).
  task automatic abort_attack(input logic [2:0] bits, input int use_reset);
    feed_bits(bits);
    wait_state(S_STRIKE, "abort_reach_strike");
    clk1();
    bus.dodge_r = ~bits[0];
    bus.dodge_l = bits[0];
    if (use_reset != 0) reset = 1'b1;
    else bus.run = 1'b0;
    clk1();
    bus.dodge_r = 1'b0;
    bus.dodge_l = 1'b0;
    chk(use_reset != 0 ? "reset_abort_state" : "run_abort_state", int'(bus.state), int'(S_IDLE));
    chk(use_reset != 0 ? "reset_abort_outputs" : "run_abort_pulses",
        int'({bus.lfsr_enable, bus.windup, bus.strike, bus.hit_player, bus.dodged}), 0);
    if (use_reset != 0) begin
      chk("reset_abort_side", int'(bus.attack_side), 0);
      model_wlen = int'(WINDUP_TICKS);
      reset = 1'b0;
    end else begin
      clk1();
      chk("run_low_idle", int'(bus.state), int'(S_IDLE));
      bus.run = 1'b1;
    end
  endtask

  initial begin
    int guard;
    bus.run        = 1'b0;
    bus.tick       = 1'b0;
    bus.random_pos = 1'b0;
    bus.dodge_l    = 1'b0;
    bus.dodge_r    = 1'b0;
    repeat (3) clk1();
    chk("reset_state", int'(bus.state), int'(S_IDLE));
    chk("reset_outputs", int'({bus.lfsr_enable, bus.attack_side, bus.windup,
                               bus.strike, bus.hit_player, bus.dodged}), 0);
    reset = 1'b0;
    repeat (4) clk1();
    chk("idle_no_run", int'({bus.state, bus.lfsr_enable}), 0);
    bus.run = 1'b1;

    attack(3'b101, 2, 0);   // side 1, wait 10, wrong-side dodge held -> hit
    attack(3'b010, 1, 2);   // side 0, dodge_r on 2nd strike tick
    attack(3'b111, 1, 4);   // side 1, dodge_l on final tick: dodge wins
    attack(3'b000, 3, 1);   // both dodges count as correct
    abort_attack(3'b110, 0);
    abort_attack(3'b001, 1);
    for (int i = 0; i < 10; i++) attack(3'($urandom_range(0, 7)), 0, 0);
    attack(3'b011, 0, 0);   // windup stays at the floor

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      clk1();
      guard++;
    end
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
